acc283_stage: RTL

Nibble-serial accumulator stage downstream of the 74HC283 adder slice. Each accepted command adds or subtracts an operand into a WIDTH-bit accumulator register, one 4-bit nibble per clock, using a single 283-equivalent adder with a registered ripple carry. It presents the accumulated result, carry and overflow flags to the next stage under a valid/ready handshake.

---
 rtl/acc283_pkg.sv | 22 ++
 rtl/acc283_stage_nibble_add4.sv | 14 +
 rtl/acc283_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/acc283_pkg.sv
// Shared types for the nibble-serial accumulator stage: op encoding, FSM states
// and the nibble-count helper.
package acc283_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_ADD   = 2'b10,
        OP_SUB   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nib_count(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/acc283_stage_nibble_add4.sv
// 4-bit adder slice with 74HC283 behaviour.
// Latency: combinational. Backpressure: none.
// Not applicable: no handshake.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/acc283_stage.sv
// Nibble-serial accumulator: CLEAR/LOAD in one edge, ADD/SUB over WIDTH/4 edges via one 4-bit adder.
// Latency: CLEAR/LOAD result valid at accept edge; ADD/SUB valid NIB edges after accept.
// Backpressure: result held in DONE until out_ready; in_ready low meanwhile. Saturation under ACC283_SAT_EN.
module acc283_stage
    import acc283_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic [WIDTH-1:0] acc_q,
    output logic             acc_cout,
    output logic             acc_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NIB = nib_count(WIDTH);
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0] a_nib, b_nib, s_nib;
    logic       c4;

    assign a_nib = acc_q[4*k_q +: 4];
    assign b_nib = b_q[4*k_q +: 4];

    nibble_add4 u_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c4)
    );

`ifdef ACC283_SAT_EN
    // Saturation direction depends on the op, which b_q alone cannot tell us.
    logic sub_q, sub_d;
    assign sub_d = (state_q == ST_IDLE && in_valid) ? (in_op == OP_SUB) : sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (op_e'(in_op))
                        OP_CLEAR: begin
                            acc_d   = '0;
                            cout_d  = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        OP_LOAD: begin
                            acc_d   = in_data;
                            cout_d  = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        OP_ADD: begin
                            b_d     = in_data;
                            carry_d = in_cin;
                            k_d     = '0;
                            state_d = ST_EXEC;
                        end
                        default: begin
                            b_d     = ~in_data;
                            carry_d = 1'b1;
                            k_d     = '0;
                            state_d = ST_EXEC;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                acc_d[4*k_q +: 4] = s_nib;
                carry_d           = c4;
                k_d               = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    cout_d  = c4;
                    ovf_d   = (a_nib[3] == b_nib[3]) && (s_nib[3] != a_nib[3]);
                    k_d     = '0;
                    state_d = ST_DONE;
`ifdef ACC283_SAT_EN
                    if (!sub_q && c4)     acc_d = '1;
                    else if (sub_q && !c4) acc_d = '0;
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_cout  = cout_q;
    assign acc_ovf   = ovf_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

endmodule
